// File: rtl/audio_i2s_frame_ctrl.sv
// I2S frame controller for a WM8731 running as clock master: ADC deserializer and DAC serializer.
// Optional build macro LOOPBACK_BYPASS_EN routes every captured ADC pair into the DAC pending buffer.
module audio_i2s_frame_ctrl #(
   parameter int DATA_W = 16
) (
   input  logic              iCLK,
   input  logic              iRST,
   input  logic              iAUD_BCLK,
   input  logic              iAUD_ADCLRCK,
   input  logic              iAUD_DACLRCK,
   input  logic              iAUD_ADCDAT,
   output logic              oAUD_DACDAT,
   output logic [DATA_W-1:0] oADC_L,
   output logic [DATA_W-1:0] oADC_R,
   output logic              oADC_VALID,
   input  logic [DATA_W-1:0] iDAC_L,
   input  logic [DATA_W-1:0] iDAC_R,
   input  logic              iDAC_VALID,
   output logic              oDAC_READY,
   output logic              oUNDERRUN
);

   localparam int CW = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {RX_IDLE, RX_SKIP, RX_SHIFT, RX_HOLD} rx_state_e;
   typedef enum logic {TX_IDLE, TX_RUN} tx_state_e;

   // [0],[1] form the synchronizer; [2] is the registered copy used for edge detection
   logic [2:0] bclk_sync_q;
   logic [2:0] adclrc_sync_q;
   logic [2:0] daclrc_sync_q;
   logic [1:0] adcdat_sync_q;

   always_ff @(posedge iCLK) begin
      bclk_sync_q   <= {bclk_sync_q[1:0], iAUD_BCLK};
      adclrc_sync_q <= {adclrc_sync_q[1:0], iAUD_ADCLRCK};
      daclrc_sync_q <= {daclrc_sync_q[1:0], iAUD_DACLRCK};
      adcdat_sync_q <= {adcdat_sync_q[0], iAUD_ADCDAT};
   end

   logic bclk_rise, bclk_fall;
   logic adclrc_lvl, adclrc_fall, adclrc_edge;
   logic daclrc_lvl, daclrc_fall, daclrc_edge;
   logic adc_bit;

   assign bclk_rise   = bclk_sync_q[1] & ~bclk_sync_q[2];
   assign bclk_fall   = ~bclk_sync_q[1] & bclk_sync_q[2];
   assign adclrc_lvl  = adclrc_sync_q[1];
   assign adclrc_fall = ~adclrc_sync_q[1] & adclrc_sync_q[2];
   assign adclrc_edge = adclrc_sync_q[1] ^ adclrc_sync_q[2];
   assign daclrc_lvl  = daclrc_sync_q[1];
   assign daclrc_fall = ~daclrc_sync_q[1] & daclrc_sync_q[2];
   assign daclrc_edge = daclrc_sync_q[1] ^ daclrc_sync_q[2];
   assign adc_bit     = adcdat_sync_q[1];

   // ---------------- RX FSM ----------------
   rx_state_e rx_state_q, rx_state_d;
   logic              rx_chan_q, rx_chan_d;
   logic [CW-1:0]     rx_cnt_q, rx_cnt_d;
   logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
   logic [DATA_W-1:0] left_sh_q, left_sh_d;
   logic              left_ok_q, left_ok_d;
   logic [DATA_W-1:0] adc_l_q, adc_l_d;
   logic [DATA_W-1:0] adc_r_q, adc_r_d;
   logic              adc_vld_q, adc_vld_d;
   logic              rx_last, rx_start, rx_shift, rx_done;
   logic [DATA_W-1:0] rx_word;

   always_ff @(posedge iCLK) begin
      if (iRST) rx_state_q <= RX_IDLE;
      else      rx_state_q <= rx_state_d;
   end

   assign rx_last = (rx_cnt_q == CW'(DATA_W - 1));

   always_comb begin
      rx_state_d = rx_state_q;
      case (rx_state_q)
         RX_IDLE:  if (adclrc_fall) rx_state_d = RX_SKIP;
         RX_SKIP:  if (adclrc_edge) rx_state_d = RX_SKIP;
                   else if (bclk_rise) rx_state_d = RX_SHIFT;
         RX_SHIFT: if (adclrc_edge) rx_state_d = RX_SKIP;
                   else if (bclk_rise && rx_last) rx_state_d = RX_HOLD;
         RX_HOLD:  if (adclrc_edge) rx_state_d = RX_SKIP;
         default:  rx_state_d = RX_IDLE;
      endcase
   end

   // Only a left-channel start releases the receiver from IDLE; afterwards any LRCK edge restarts a word
   always_comb begin
      rx_start = (rx_state_q == RX_IDLE) ? adclrc_fall : adclrc_edge;
      rx_shift = (rx_state_q == RX_SHIFT) && bclk_rise && !adclrc_edge;
      rx_done  = rx_shift && rx_last;
      rx_word  = {rx_sh_q[DATA_W-2:0], adc_bit};
   end

   always_comb begin
      rx_chan_d = rx_chan_q;
      rx_cnt_d  = rx_cnt_q;
      rx_sh_d   = rx_sh_q;
      left_sh_d = left_sh_q;
      left_ok_d = left_ok_q;
      adc_l_d   = adc_l_q;
      adc_r_d   = adc_r_q;
      adc_vld_d = 1'b0;
      if (rx_start) begin
         rx_chan_d = adclrc_lvl;
         rx_cnt_d  = '0;
         if (!adclrc_lvl) left_ok_d = 1'b0;
      end else if (rx_shift) begin
         rx_sh_d  = rx_word;
         rx_cnt_d = rx_cnt_q + 1'b1;
         if (rx_done) begin
            if (!rx_chan_q) begin
               left_sh_d = rx_word;
               left_ok_d = 1'b1;
            end else if (left_ok_q) begin
               adc_l_d   = left_sh_q;
               adc_r_d   = rx_word;
               adc_vld_d = 1'b1;
               left_ok_d = 1'b0;
            end
         end
      end
   end

   // ---------------- TX FSM ----------------
   tx_state_e tx_state_q, tx_state_d;
   logic [DATA_W-1:0] pend_l_q, pend_l_d;
   logic [DATA_W-1:0] pend_r_q, pend_r_d;
   logic              pend_full_q, pend_full_d;
   logic [DATA_W-1:0] act_l_q, act_l_d;
   logic [DATA_W-1:0] act_r_q, act_r_d;
   logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
   logic [CW-1:0]     tx_cnt_q, tx_cnt_d;
   logic              dacdat_q, dacdat_d;
   logic              underrun_q, underrun_d;
   logic              wr_en, tx_load, tx_shift;
   logic [DATA_W-1:0] wr_l, wr_r;

`ifdef LOOPBACK_BYPASS_EN
   logic dac_unused;
   assign dac_unused = ^{iDAC_L, iDAC_R, iDAC_VALID};
   assign wr_en = adc_vld_q;
   assign wr_l  = adc_l_q;
   assign wr_r  = adc_r_q;
`else
   assign wr_en = iDAC_VALID && !pend_full_q;
   assign wr_l  = iDAC_L;
   assign wr_r  = iDAC_R;
`endif

   always_ff @(posedge iCLK) begin
      if (iRST) tx_state_q <= TX_IDLE;
      else      tx_state_q <= tx_state_d;
   end

   always_comb begin
      tx_state_d = tx_state_q;
      case (tx_state_q)
         TX_IDLE: if (daclrc_fall) tx_state_d = TX_RUN;
         TX_RUN:  tx_state_d = TX_RUN;
         default: tx_state_d = TX_IDLE;
      endcase
   end

   // An LRCK edge takes priority over a coincident BCLK fall
   always_comb begin
      tx_load  = (tx_state_q == TX_RUN) ? daclrc_edge : daclrc_fall;
      tx_shift = (tx_state_q == TX_RUN) && bclk_fall && !daclrc_edge;
   end

   always_comb begin
      pend_l_d    = pend_l_q;
      pend_r_d    = pend_r_q;
      pend_full_d = pend_full_q;
      act_l_d     = act_l_q;
      act_r_d     = act_r_q;
      tx_sh_d     = tx_sh_q;
      tx_cnt_d    = tx_cnt_q;
      dacdat_d    = dacdat_q;
      underrun_d  = 1'b0;
      if (daclrc_fall) begin
         if (pend_full_q) begin
            act_l_d     = pend_l_q;
            act_r_d     = pend_r_q;
            pend_full_d = wr_en;
            if (wr_en) begin
               pend_l_d = wr_l;
               pend_r_d = wr_r;
            end
         end else if (wr_en) begin
            act_l_d = wr_l;
            act_r_d = wr_r;
         end else begin
            act_l_d    = '0;
            act_r_d    = '0;
            underrun_d = 1'b1;
         end
      end else if (wr_en) begin
         pend_l_d    = wr_l;
         pend_r_d    = wr_r;
         pend_full_d = 1'b1;
      end
      if (tx_load) begin
         tx_sh_d  = daclrc_lvl ? act_r_d : act_l_d;
         tx_cnt_d = '0;
      end else if (tx_shift) begin
         if (tx_cnt_q != CW'(DATA_W)) begin
            dacdat_d = tx_sh_q[DATA_W-1];
            tx_sh_d  = tx_sh_q << 1;
            tx_cnt_d = tx_cnt_q + 1'b1;
         end else begin
            dacdat_d = 1'b0;
         end
      end
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         rx_chan_q   <= 1'b0;
         rx_cnt_q    <= '0;
         rx_sh_q     <= '0;
         left_sh_q   <= '0;
         left_ok_q   <= 1'b0;
         adc_l_q     <= '0;
         adc_r_q     <= '0;
         adc_vld_q   <= 1'b0;
         pend_l_q    <= '0;
         pend_r_q    <= '0;
         pend_full_q <= 1'b0;
         act_l_q     <= '0;
         act_r_q     <= '0;
         tx_sh_q     <= '0;
         tx_cnt_q    <= '0;
         dacdat_q    <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         rx_chan_q   <= rx_chan_d;
         rx_cnt_q    <= rx_cnt_d;
         rx_sh_q     <= rx_sh_d;
         left_sh_q   <= left_sh_d;
         left_ok_q   <= left_ok_d;
         adc_l_q     <= adc_l_d;
         adc_r_q     <= adc_r_d;
         adc_vld_q   <= adc_vld_d;
         pend_l_q    <= pend_l_d;
         pend_r_q    <= pend_r_d;
         pend_full_q <= pend_full_d;
         act_l_q     <= act_l_d;
         act_r_q     <= act_r_d;
         tx_sh_q     <= tx_sh_d;
         tx_cnt_q    <= tx_cnt_d;
         dacdat_q    <= dacdat_d;
         underrun_q  <= underrun_d;
      end
   end

   assign oAUD_DACDAT = dacdat_q;
   assign oADC_L      = adc_l_q;
   assign oADC_R      = adc_r_q;
   assign oADC_VALID  = adc_vld_q;
   assign oDAC_READY  = !pend_full_q;
   assign oUNDERRUN   = underrun_q;

endmodule

// File: tb/tb_audio_i2s_frame_ctrl.sv
// Bench for audio_i2s_frame_ctrl: codec BFM (ADC serializer, DAC decoder) plus frame-level model.
module tb_audio_i2s_frame_ctrl;
   localparam int DW   = 16;
   localparam int HALF = 160;

   logic clk = 1'b0;
   always #10 clk = ~clk;

   logic          iRST, bclk, adclrc, daclrc, adcdat;
   logic          oAUD_DACDAT, oADC_VALID, oDAC_READY, oUNDERRUN;
   logic [DW-1:0] oADC_L, oADC_R, iDAC_L, iDAC_R;
   logic          iDAC_VALID;

   audio_i2s_frame_ctrl #(.DATA_W(DW)) dut (
      .iCLK(clk), .iRST(iRST), .iAUD_BCLK(bclk), .iAUD_ADCLRCK(adclrc),
      .iAUD_DACLRCK(daclrc), .iAUD_ADCDAT(adcdat), .oAUD_DACDAT(oAUD_DACDAT),
      .oADC_L(oADC_L), .oADC_R(oADC_R), .oADC_VALID(oADC_VALID),
      .iDAC_L(iDAC_L), .iDAC_R(iDAC_R), .iDAC_VALID(iDAC_VALID),
      .oDAC_READY(oDAC_READY), .oUNDERRUN(oUNDERRUN)
   );

   typedef struct {
      logic [DW-1:0] adc_l;
      logic [DW-1:0] adc_r;
      bit            offer;
      logic [DW-1:0] dac_l;
      logic [DW-1:0] dac_r;
      int            short_left;
      int            rst_k;
      int            exp_valid;
   } vec_t;

   int checks = 0;
   int errors = 0;
   int vld_cnt = 0;
   int und_cnt = 0;
   logic [DW-1:0] cap_l = '0, cap_r = '0;
   logic [DW-1:0] dac_word [2];
   bit ready_probe = 0;
   bit prev_have = 0;
   logic [DW-1:0] prev_l = '0, prev_r = '0;

   always @(negedge clk) begin
      if (oADC_VALID) begin
         vld_cnt++;
         cap_l = oADC_L;
         cap_r = oADC_R;
      end
      if (oUNDERRUN) und_cnt++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_dacdat"}, oAUD_DACDAT, 0);
      check({tag, "_adc_l"}, oADC_L, 0);
      check({tag, "_adc_r"}, oADC_R, 0);
      check({tag, "_valid"}, oADC_VALID, 0);
      check({tag, "_ready"}, oDAC_READY, 1);
      check({tag, "_underrun"}, oUNDERRUN, 0);
   endtask

   task automatic probe_ready();
      int n = 1;
      @(negedge clk);
      while (!oDAC_READY && n < 8) begin
         n++;
         @(negedge clk);
      end
      checks++;
      if (!(n >= 2 && n <= 5) || !oDAC_READY) begin
         errors++;
         $display("FAIL ready_after_lrck_fall actual_cycles=%0d required=2..5", n);
      end
   endtask

   // One BCLK period, starting at the falling edge where the codec changes LRCK/data
   task automatic bclk_cycle(input logic lr, input logic dat, input int h, input int k);
      bclk = 1'b0; adclrc = lr; daclrc = lr; adcdat = dat;
      if (ready_probe && h == 0 && k == 0) probe_ready();
      #HALF;
      if (k >= 1 && k <= DW) dac_word[h] = {dac_word[h][DW-2:0], oAUD_DACDAT};
      bclk = 1'b1;
      #HALF;
   endtask

   task automatic do_reset_mid();
      @(negedge clk); iRST = 1'b1;
      repeat (2) @(negedge clk);
      check_reset_outputs("midrst");
      @(negedge clk); iRST = 1'b0;
   endtask

   task automatic run_frame(input logic [DW-1:0] al, input logic [DW-1:0] ar,
                            input int short_left, input int rst_k);
      for (int h = 0; h < 2; h++) begin
         logic [DW-1:0] w;
         int nbits;
         w = (h == 0) ? al : ar;
         nbits = (h == 0 && short_left > 0) ? short_left + 1 : 32;
         for (int k = 0; k < nbits; k++) begin
            if (h == 1 && k == rst_k) do_reset_mid();
            bclk_cycle(h[0], (k >= 1 && k <= DW) ? w[DW-k] : 1'b0, h, k);
         end
      end
   endtask

   task automatic offer(input logic [DW-1:0] l, input logic [DW-1:0] r);
`ifdef LOOPBACK_BYPASS_EN
      @(negedge clk); iDAC_L = l; iDAC_R = r; iDAC_VALID = 1'b1;
      @(negedge clk); iDAC_VALID = 1'b0;
`else
      int n = 0;
      @(negedge clk); iDAC_L = l; iDAC_R = r; iDAC_VALID = 1'b1;
      while (!oDAC_READY && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!oDAC_READY) begin
         checks++; errors++;
         $display("FAIL offer_timeout actual_ready=0 required=1");
      end
      @(negedge clk); iDAC_VALID = 1'b0;
      check("ready_low_after_accept", oDAC_READY, 0);
`endif
   endtask

   task automatic apply_frame(input vec_t v, input int idx);
      bit have;
      logic [DW-1:0] el, er;
      int v0, u0;
`ifdef LOOPBACK_BYPASS_EN
      have = prev_have; el = prev_l; er = prev_r;
`else
      have = v.offer; el = v.dac_l; er = v.dac_r;
`endif
      if (!have) begin el = '0; er = '0; end
      if (v.offer) offer(v.dac_l, v.dac_r);
      v0 = vld_cnt; u0 = und_cnt;
      ready_probe = have;
      run_frame(v.adc_l, v.adc_r, v.short_left, v.rst_k);
      ready_probe = 0;
      repeat (2) @(negedge clk);
      check($sformatf("f%0d_valid_count", idx), vld_cnt - v0, v.exp_valid);
      if (v.exp_valid == 1) begin
         check($sformatf("f%0d_adc_l", idx), cap_l, v.adc_l);
         check($sformatf("f%0d_adc_r", idx), cap_r, v.adc_r);
      end
      if (v.short_left == 0 && v.rst_k < 0)
         check($sformatf("f%0d_dac_l", idx), dac_word[0], el);
      if (v.rst_k < 0)
         check($sformatf("f%0d_dac_r", idx), dac_word[1], er);
      check($sformatf("f%0d_underrun", idx), und_cnt - u0, have ? 0 : 1);
      prev_have = (v.exp_valid == 1);
      prev_l = v.adc_l;
      prev_r = v.adc_r;
   endtask

   vec_t tbl [7];

   initial begin
      tbl[0] = '{16'h1234, 16'hA5C3, 1, 16'h8001, 16'h7FFE, 0, -1, 1};
      tbl[1] = '{16'h0F0F, 16'hF0F0, 0, 16'h0000, 16'h0000, 0, -1, 1};
      tbl[2] = '{16'h5555, 16'hAAAA, 1, 16'h0000, 16'hFFFF, 9, -1, 0};
      tbl[3] = '{16'h7FFF, 16'h8000, 1, 16'h1357, 16'h2468, 0, -1, 1};
      tbl[4] = '{16'h4321, 16'h8765, 0, 16'h0000, 16'h0000, 0, 8, 0};
      tbl[5] = '{16'h0001, 16'hFFFF, 1, 16'hABCD, 16'h0123, 0, -1, 1};
      tbl[6] = '{16'hFFFF, 16'h0000, 1, 16'h8000, 16'h7FFF, 0, -1, 1};

      iRST = 1'b1; bclk = 1'b1; adclrc = 1'b1; daclrc = 1'b1; adcdat = 1'b0;
      iDAC_L = '0; iDAC_R = '0; iDAC_VALID = 1'b0;
      #3;
      repeat (4) @(negedge clk);
      check_reset_outputs("rst");
      iRST = 1'b0;
      repeat (4) @(negedge clk);
      check("idle_dacdat", oAUD_DACDAT, 0);

      for (int i = 0; i < 7; i++) apply_frame(tbl[i], i);

      for (int i = 0; i < 20; i++) begin
         vec_t v;
         v.adc_l = DW'($urandom);
         v.adc_r = DW'($urandom);
         v.offer = $urandom_range(0, 1) == 1;
         v.dac_l = DW'($urandom);
         v.dac_r = DW'($urandom);
         v.short_left = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : 0;
         v.rst_k = -1;
         v.exp_valid = (v.short_left == 0) ? 1 : 0;
         apply_frame(v, 100 + i);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
